// File: rtl/float_to_posit.sv
// IEEE-754 single precision to posit<N,es> converter.
// Four register ranks (operand capture, decode, regime build, sign/outputs); done trails start by three edges.
module float_to_posit #(
    parameter int N  = 32,
    parameter int es = 2
) (
    input  logic         aclk,
    input  logic         reset,
    input  logic [31:0]  in,
    input  logic         start,
    output logic [N-1:0] result,
    output logic         inf,
    output logic         zero,
    output logic         done
);

    localparam int ESW        = (es == 0) ? 1 : es;
    localparam int TAIL_SHIFT = 62 - es - 23;
    localparam logic signed [8:0] K_MAX = 9'(N - 2);
    localparam logic signed [8:0] K_MIN = 9'sd0 - K_MAX;
    localparam logic [N-1:0] NAR_WORD = {1'b1, {(N-1){1'b0}}};

    // Regime/exponent/fraction string left-aligned, sliced to N-1 bits, with saturation at both ends.
    function automatic logic [N-1:0] build_magnitude(
        input logic signed [8:0] k,
        input logic [ESW-1:0]    e,
        input logic [22:0]       frac
    );
        logic [26:0]        tail;
        logic signed [63:0] word;
        logic [8:0]         sh;
        tail = (27'(e) << 23) | 27'(frac);
        if (k >= 9'sd0) begin
            word = {2'b10, 62'd0};
            sh   = $unsigned(k);
        end else begin
            word = {2'b01, 62'd0};
            sh   = $unsigned(~k);
        end
        word = word | $signed(64'(tail) << TAIL_SHIFT);
        word = word >>> sh;
        if (k > K_MAX) begin
            build_magnitude = {1'b0, {(N-1){1'b1}}};
        end else if (k < K_MIN) begin
            build_magnitude = {{(N-1){1'b0}}, 1'b1};
        end else begin
            build_magnitude = {1'b0, word[63 -: N-1]};
        end
    endfunction

    logic [31:0]        in_r;
    logic               v0_r;
    logic [7:0]         exp_s;
    logic signed [8:0]  e_full_s;
    logic signed [8:0]  k_s;
    logic [ESW-1:0]     e_s;
    logic               s1_r, sp1_r, z1_r, v1_r;
    logic signed [8:0]  k1_r;
    logic [ESW-1:0]     e1_r;
    logic [22:0]        f1_r;
    logic [N-1:0]       mag_s;
    logic               s2_r, sp2_r, z2_r, v2_r;
    logic [N-1:0]       mag2_r;

    assign exp_s    = in_r[30:23];
    assign e_full_s = $signed({1'b0, exp_s}) - 9'sd127;
    assign k_s      = e_full_s >>> es;
    assign e_s      = (es == 0) ? {ESW{1'b0}} : e_full_s[ESW-1:0];
    assign mag_s    = build_magnitude(k1_r, e1_r, f1_r);

    // Operand capture; an X start falls into the else branch and stays invalid.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            in_r <= 32'd0;
            v0_r <= 1'b0;
        end else begin
            in_r <= in;
            if (start == 1'b1) begin
                v0_r <= 1'b1;
            end else begin
                v0_r <= 1'b0;
            end
        end
    end

    // Decode: classify and split the unbiased exponent into regime k and exponent e.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            s1_r  <= 1'b0;
            sp1_r <= 1'b0;
            z1_r  <= 1'b0;
            k1_r  <= 9'sd0;
            e1_r  <= {ESW{1'b0}};
            f1_r  <= 23'd0;
            v1_r  <= 1'b0;
        end else begin
            s1_r  <= in_r[31];
            sp1_r <= (exp_s == 8'hFF);
            z1_r  <= (exp_s == 8'h00);
            k1_r  <= k_s;
            e1_r  <= e_s;
            f1_r  <= in_r[22:0];
            v1_r  <= v0_r;
        end
    end

    // Magnitude build.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            s2_r   <= 1'b0;
            sp2_r  <= 1'b0;
            z2_r   <= 1'b0;
            mag2_r <= {N{1'b0}};
            v2_r   <= 1'b0;
        end else begin
            s2_r   <= s1_r;
            sp2_r  <= sp1_r;
            z2_r   <= z1_r;
            mag2_r <= mag_s;
            v2_r   <= v1_r;
        end
    end

    // Sign application and special-case override into the output registers.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            result <= {N{1'b0}};
            inf    <= 1'b0;
            zero   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= v2_r;
            if (sp2_r) begin
                result <= NAR_WORD;
                inf    <= 1'b1;
                zero   <= 1'b0;
            end else if (z2_r) begin
                result <= {N{1'b0}};
                inf    <= 1'b0;
                zero   <= 1'b1;
            end else begin
                if (s2_r) begin
                    result <= ~mag2_r + N'(1);
                end else begin
                    result <= mag2_r;
                end
                inf  <= 1'b0;
                zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_float_to_posit.sv
// Directed and randomized checks of float_to_posit with N=32, es=2.
module tb_float_to_posit;

    logic        aclk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] in;
    logic [31:0] result;
    logic        inf;
    logic        zero;
    logic        done;
    int          n_checks = 0;
    int          n_fail   = 0;

    float_to_posit #(.N(32), .es(2)) dut (
        .aclk(aclk), .reset(reset), .in(in), .start(start),
        .result(result), .inf(inf), .zero(zero), .done(done)
    );

    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Bit-serial reference: returns {inf, zero, result}.
    function automatic logic [33:0] ref_posit(input logic [31:0] f);
        int E, k, pos;
        logic [1:0]  eb;
        logic [30:0] m;
        logic [31:0] w;
        if (f[30:23] == 8'hFF) return {1'b1, 1'b0, 32'h80000000};
        if (f[30:23] == 8'h00) return {1'b0, 1'b1, 32'h00000000};
        E = int'(f[30:23]) - 127;
        if (E >= 0) k = E / 4;
        else        k = -((-E + 3) / 4);
        eb = 2'(E - 4 * k);
        m = 31'd0;
        if (k > 30) begin
            m = 31'h7FFFFFFF;
        end else if (k < -30) begin
            m = 31'd1;
        end else begin
            pos = 30;
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) begin
                    if (pos >= 0) m[pos] = 1'b1;
                    pos--;
                end
                pos--;
            end else begin
                pos = pos + k;
                m[pos] = 1'b1;
                pos--;
            end
            for (int b = 1; b >= 0; b--) begin
                if (pos >= 0) m[pos] = eb[b];
                pos--;
            end
            for (int b = 22; b >= 0; b--) begin
                if (pos >= 0) m[pos] = f[b];
                pos--;
            end
        end
        w = {1'b0, m};
        if (f[31]) w = -w;
        return {2'b00, w};
    endfunction

    // Send one operand and wait (bounded) for its done; lat counts edges after the sampling edge.
    task automatic run_one(input logic [31:0] v, output logic [31:0] r,
                           output logic i, output logic z, output bit got, output int lat);
        r = 32'd0; i = 1'b0; z = 1'b0; got = 1'b0; lat = -1;
        @(negedge aclk);
        in = v; start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            if (done) begin
                got = 1'b1; r = result; i = inf; z = zero; lat = c - 1;
            end else begin
                @(negedge aclk);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in = 32'd0;
        #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++;
        if ({result, inf, zero} !== 34'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h/%b/%b want 0/0/0", result, inf, zero);
        end
        @(negedge aclk); @(negedge aclk);
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vin  [3] = '{32'h3F800000, 32'h40800000, 32'h3FC00000};
        logic [31:0] vexp [3] = '{32'h40000000, 32'h50000000, 32'h44000000};
        @(negedge aclk);
        in = vin[0]; start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge aclk);
            n_checks++;
            if (done !== (c >= 4 && c <= 6)) begin
                n_fail++; $display("FAIL b2b_done c=%0d: got %b want %b", c, done, (c >= 4 && c <= 6));
            end else if (done) begin
                n_checks++;
                if (result !== vexp[c-4]) begin
                    n_fail++; $display("FAIL b2b_result c=%0d: got %h want %h", c, result, vexp[c-4]);
                end
            end
            if (c < 3) begin in = vin[c]; start = 1'b1; end
            else start = 1'b0;
        end
    endtask

    task automatic test_negative();
        logic [31:0] r; logic i, z; bit got; int lat;
        run_one(32'hBF800000, r, i, z, got, lat);
        n_checks++;
        if (!got || lat != 3) begin n_fail++; $display("FAIL neg_latency: got %0d want 3", lat); end
        n_checks++;
        if ({r, i, z} !== {32'hC0000000, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL neg_one: got %h/%b/%b want c0000000/0/0", r, i, z);
        end
    endtask

    task automatic test_special();
        logic [31:0] vin  [5] = '{32'h00000000, 32'h80000000, 32'h00000001, 32'h7F800000, 32'hFFC00000};
        logic [33:0] vexp [5] = '{{2'b01, 32'h0}, {2'b01, 32'h0}, {2'b01, 32'h0},
                                  {2'b10, 32'h80000000}, {2'b10, 32'h80000000}};
        logic [31:0] r; logic i, z; bit got; int lat;
        for (int t = 0; t < 5; t++) begin
            run_one(vin[t], r, i, z, got, lat);
            n_checks++;
            if (!got || {i, z, r} !== vexp[t]) begin
                n_fail++; $display("FAIL special in=%h: got %b%b/%h want %h", vin[t], i, z, r, vexp[t]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] vin  [7] = '{32'h7F000000, 32'h00800000, 32'hFF000000, 32'h7B800000,
                                  32'h05800000, 32'h07000000, 32'h80800000};
        logic [31:0] vexp [7] = '{32'h7FFFFFFF, 32'h00000001, 32'h80000001, 32'h7FFFFFFF,
                                  32'h00000002, 32'h00000003, 32'hFFFFFFFF};
        logic [31:0] r; logic i, z; bit got; int lat;
        for (int t = 0; t < 7; t++) begin
            run_one(vin[t], r, i, z, got, lat);
            n_checks++;
            if (!got || {i, z, r} !== {2'b00, vexp[t]}) begin
                n_fail++; $display("FAIL sat in=%h: got %b%b/%h want 00/%h", vin[t], i, z, r, vexp[t]);
            end
        end
    endtask

    task automatic test_reset_in_flight();
        logic [31:0] r; logic i, z; bit got; int lat;
        @(negedge aclk); in = 32'h3F800000; start = 1'b1;
        @(negedge aclk); in = 32'h40800000;
        @(negedge aclk); start = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        n_checks++;
        if (done !== 1'b1 || result !== 32'h40000000) begin
            n_fail++; $display("FAIL flight_pre: got %b/%h want 1/40000000", done, result);
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({done, inf, zero, result} !== 35'd0) begin
            n_fail++; $display("FAIL flight_async_clear: got %b%b%b/%h want 000/0", done, inf, zero, result);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge aclk);
            if (c == 1) reset = 1'b0;
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL flight_done c=%0d: got %b want 0", c, done); end
        end
        run_one(32'h3F800000, r, i, z, got, lat);
        n_checks++;
        if (!got || lat != 3 || r !== 32'h40000000) begin
            n_fail++; $display("FAIL flight_after: got %h lat %0d want 40000000 lat 3", r, lat);
        end
    endtask

    task automatic test_random();
        logic [33:0] q[$];
        logic [33:0] ev;
        int starts = 0;
        int dones = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge aclk);
            if (done) begin
                dones++;
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra_done: got done want none");
                end else begin
                    ev = q.pop_front();
                    if ({inf, zero, result} !== ev) begin
                        n_fail++; $display("FAIL rand_result: got %b%b/%h want %h", inf, zero, result, ev);
                    end
                end
            end
            if (c < 390 && $urandom_range(0, 1) == 1) begin
                in = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
                start = 1'b1;
                q.push_back(ref_posit(in));
                starts++;
            end else begin
                start = 1'b0;
                in = $urandom;
            end
        end
        n_checks++;
        if (dones != starts || q.size() != 0) begin
            n_fail++; $display("FAIL rand_count: got %0d dones want %0d", dones, starts);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_negative();
        test_special();
        test_saturation();
        test_reset_in_flight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/float_to_posit.md
FLOAT_TO_POSIT -- requirements
Module: float_to_posit

Interface
REQ-001 SHALL have parameter N, default 32, posit output width; legal range 8..32.
REQ-002 SHALL have parameter es, default 2, posit exponent field width; legal range 0..4.
REQ-003 SHALL have port aclk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in  input  32  IEEE-754 single-precision operand.
REQ-006 SHALL have port start  input  1  qualifies in as valid this cycle.
REQ-007 SHALL have port result  output  N  encoded posit, two's-complement sign convention.
REQ-008 SHALL have port inf  output  1  operand was Inf or NaN (result is NaR).
REQ-009 SHALL have port zero  output  1  operand was +/-0 or subnormal (result is 0).
REQ-010 SHALL have port done  output  1  result/inf/zero valid this cycle.

Function
REQ-011 SHALL be a 3-stage pipeline with all outputs registered: input sampled on edge T with start=1 -> done=1 with its result during the cycle following edge T+3.
REQ-012 SHALL accept a new operand every cycle; back-to-back start pulses SHALL yield back-to-back done pulses in order, no stalls, no backpressure.
REQ-013 SHALL carry start as a per-stage valid bit; done SHALL be the stage-3 valid bit. Outputs for cycles with start=0 are don't-care except that done=0.
REQ-014 Stage 1 SHALL decode sign s=in[31], biased exponent, fraction; classify as special (exp=255), zero (exp=0, any fraction; subnormals flushed), or normal.
REQ-015 Stage 1 SHALL compute E=exp-127 (signed 9-bit), k=floor(E/2^es) (arithmetic shift), e=E mod 2^es (low es bits of E).
REQ-016 Stage 2 SHALL build the magnitude: k>=0 -> k+1 ones then a zero; k<0 -> -k zeros then a one; then es bits of e; then the 23 fraction bits; truncated to the top N-1 bits after the sign position (no rounding, truncation toward zero in magnitude).
REQ-017 SHALL saturate: k > N-2 -> magnitude 0111..1 (maxpos); k < -(N-2) -> magnitude 000..01 (minpos). A nonzero normal input SHALL never produce 0 or NaR.
REQ-018 Stage 3 SHALL apply sign: s=1 -> result = two's-complement negation of the N-bit magnitude word; s=0 -> unchanged.
REQ-019 Special input SHALL give result={1'b1,{N-1{1'b0}}}, inf=1, zero=0, regardless of sign or NaN payload.
REQ-020 Zero/subnormal input SHALL give result=0, zero=1, inf=0, regardless of sign.
REQ-021 Normal input SHALL give inf=0, zero=0.
REQ-022 X on in or start SHALL NOT propagate into valid state; start=X SHALL be treated as 0.

Reset
REQ-023 reset=1 SHALL asynchronously clear all valid bits and drive result=0, inf=0, zero=0, done=0 without waiting for aclk.
REQ-024 Operands in flight when reset asserts SHALL be discarded; no done pulse SHALL appear for them after deassertion.
REQ-025 First operand with start=1 on the first edge after reset deasserts SHALL complete with normal 3-cycle latency.

Verification (N=32, es=2)
REQ-026 in=0x3F800000 (1.0), 0x40800000 (4.0), 0x3FC00000 (1.5) on consecutive cycles with start=1 -> results 0x40000000, 0x50000000, 0x44000000 on 3 consecutive done cycles, first done exactly 3 cycles after first sample.
REQ-027 in=0xBF800000 (-1.0) -> 0xC0000000, inf=0, zero=0.
REQ-028 in=0x00000000, 0x80000000, 0x00000001 -> result 0x00000000, zero=1 each; in=0x7F800000, 0xFFC00000 -> result 0x80000000, inf=1 each.
REQ-029 in=0x7F000000 (2^127) -> 0x7FFFFFFF; in=0x00800000 (2^-126) -> 0x00000001; in=0xFF000000 -> 0x80000001.
REQ-030 Assert reset while two operands are in flight, deassert, then idle 4 cycles -> outputs 0 immediately on assertion, no done pulses during or after; subsequent 1.0 input -> 0x40000000 after 3 cycles.
REQ-031 Random normal floats at full throughput, start toggled randomly -> every done matches a software reference of REQ-014..REQ-021 in order; done count equals start count.
